// File: rtl/mm_os_stream_array.sv
// Output-stationary systolic matrix engine: C[ROWS x COLS] = A[ROWS x K] * B[K x COLS].
// Operands stream in one K-slice per beat and are skewed internally; results drain one row per beat.
module mm_os_stream_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int MAX_K      = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAX_K),
    localparam int KW        = $clog2(MAX_K+1),
    localparam int RW        = $clog2(ROWS)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [KW-1:0]                 k_len_i,
    input  logic                          signed_i,
    output logic                          busy_o,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0]    a_i,
    input  logic [COLS*DATA_WIDTH-1:0]    b_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [RW-1:0]                 out_row_o,
    output logic [COLS*ACC_WIDTH-1:0]     c_o,
    output logic                          done_o
);

    localparam int FLUSH_N = ROWS + COLS - 2;
    localparam int FW      = $clog2(FLUSH_N + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t                       state_q;
    logic [KW-1:0]                k_q;
    logic [KW-1:0]                cnt_q;
    logic [FW-1:0]                fcnt_q;
    logic                         sgn_q;
    logic [RW-1:0]                row_q;
    logic                         busy_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         done_q;
    logic [COLS*ACC_WIDTH-1:0]    c_q;

    logic [DATA_WIDTH-1:0] a_pe_q   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] a_pe_d   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_pe_q   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_pe_d   [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc_q    [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc_d    [ROWS][COLS];
    logic [DATA_WIDTH-1:0] skew_a_q [ROWS][ROWS];
    logic [DATA_WIDTH-1:0] skew_a_d [ROWS][ROWS];
    logic [DATA_WIDTH-1:0] skew_b_q [COLS][COLS];
    logic [DATA_WIDTH-1:0] skew_b_d [COLS][COLS];

    logic [DATA_WIDTH-1:0] in_a   [ROWS];
    logic [DATA_WIDTH-1:0] edge_a [ROWS];
    logic [DATA_WIDTH-1:0] in_b   [COLS];
    logic [DATA_WIDTH-1:0] edge_b [COLS];
    logic [DATA_WIDTH-1:0] west   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] north  [ROWS][COLS];

    logic                      start_ok;
    logic                      step;
    logic [RW-1:0]             row_sel;
    logic [COLS*ACC_WIDTH-1:0] c_row;

    // Product widened to the accumulator, sign- or zero-extended by job mode.
    function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b,
                                                     input logic               sgn);
        logic signed [2*DATA_WIDTH-1:0] ps;
        logic        [2*DATA_WIDTH-1:0] pu;
        ps = signed'({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * signed'({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        pu = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        if (sgn) return ACC_WIDTH'(ps);
        return ACC_WIDTH'(pu);
    endfunction

    assign start_ok = (state_q == S_IDLE) && start_i && (k_len_i != '0) && (k_len_i <= KW'(MAX_K));
    assign step     = ((state_q == S_LOAD) && in_valid_i) || (state_q == S_FLUSH);

    always_comb begin
        for (int i = 0; i < ROWS; i++)
            in_a[i] = (state_q == S_LOAD) ? a_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int j = 0; j < COLS; j++)
            in_b[j] = (state_q == S_LOAD) ? b_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;

        // Row i / column j enter the array through a chain of i / j skew stages.
        edge_a[0] = in_a[0];
        for (int i = 1; i < ROWS; i++) edge_a[i] = skew_a_q[i][i-1];
        edge_b[0] = in_b[0];
        for (int j = 1; j < COLS; j++) edge_b[j] = skew_b_q[j][j-1];

        for (int i = 0; i < ROWS; i++) begin
            west[i][0] = edge_a[i];
            for (int j = 1; j < COLS; j++) west[i][j] = a_pe_q[i][j-1];
        end
        for (int j = 0; j < COLS; j++) begin
            north[0][j] = edge_b[j];
            for (int i = 1; i < ROWS; i++) north[i][j] = b_pe_q[i-1][j];
        end

        a_pe_d   = a_pe_q;
        b_pe_d   = b_pe_q;
        acc_d    = acc_q;
        skew_a_d = skew_a_q;
        skew_b_d = skew_b_q;

        if (start_ok) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_pe_d[i][j] = '0;
                    b_pe_d[i][j] = '0;
                    acc_d[i][j]  = '0;
                end
            for (int i = 0; i < ROWS; i++)
                for (int s = 0; s < ROWS; s++) skew_a_d[i][s] = '0;
            for (int j = 0; j < COLS; j++)
                for (int s = 0; s < COLS; s++) skew_b_d[j][s] = '0;
        end else if (step) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_pe_d[i][j] = west[i][j];
                    b_pe_d[i][j] = north[i][j];
                    acc_d[i][j]  = acc_q[i][j] + mul_ext(west[i][j], north[i][j], sgn_q);
                end
            for (int i = 1; i < ROWS; i++) begin
                skew_a_d[i][0] = in_a[i];
                for (int s = 1; s < ROWS; s++) skew_a_d[i][s] = skew_a_q[i][s-1];
            end
            for (int j = 1; j < COLS; j++) begin
                skew_b_d[j][0] = in_b[j];
                for (int s = 1; s < COLS; s++) skew_b_d[j][s] = skew_b_q[j][s-1];
            end
        end
    end

    // Row presented next: current row on DRAIN entry, following row after a handshake.
    always_comb begin
        row_sel = out_valid_q ? row_q + RW'(1) : row_q;
        c_row   = '0;
        for (int j = 0; j < COLS; j++)
            c_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_sel][j];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            for (int i = 0; i < ROWS; i++)
                for (int s = 0; s < ROWS; s++) skew_a_q[i][s] <= '0;
            for (int j = 0; j < COLS; j++)
                for (int s = 0; s < COLS; s++) skew_b_q[j][s] <= '0;
        end else begin
            a_pe_q   <= a_pe_d;
            b_pe_q   <= b_pe_d;
            acc_q    <= acc_d;
            skew_a_q <= skew_a_d;
            skew_b_q <= skew_b_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            sgn_q       <= 1'b0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            c_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        k_q        <= k_len_i;
                        sgn_q      <= signed_i;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        if (cnt_q == k_q - KW'(1)) begin
                            in_ready_q <= 1'b0;
                            fcnt_q     <= '0;
                            state_q    <= S_FLUSH;
                        end else begin
                            cnt_q <= cnt_q + KW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (fcnt_q == FW'(FLUSH_N - 1)) begin
                        row_q   <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        c_q         <= c_row;
                    end else if (out_ready_i) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            out_valid_q <= 1'b0;
                            c_q         <= '0;
                            row_q       <= '0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            row_q <= row_sel;
                            c_q   <= c_row;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_row_o   = row_q;
    assign c_o         = c_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mm_os_stream_array.sv
// Directed bench for mm_os_stream_array: fixed-value jobs, stalls, ignored starts and async resets.
module tb_mm_os_stream_array;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int MK = 16;
    localparam int AW = 2*DW + $clog2(MK);
    localparam int KW = $clog2(MK+1);
    localparam int RW = $clog2(R);
    localparam int CW = AW*C;
    typedef logic [CW-1:0] w_t;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            signed_i;
    logic            busy_o;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [R*DW-1:0] a_i;
    logic [C*DW-1:0] b_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [RW-1:0]   out_row_o;
    logic [CW-1:0]   c_o;
    logic            done_o;

    logic [DW-1:0] A [R][MK];
    logic [DW-1:0] B [MK][C];
    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mm_os_stream_array #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .MAX_K(MK)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .k_len_i(k_len_i),
        .signed_i(signed_i), .busy_o(busy_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_row_o(out_row_o), .c_o(c_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_c(input int i, input int j, input int k, input bit sgn);
        int s;
        int av;
        int bv;
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
            av = sgn ? int'($signed(A[i][kk])) : int'(A[i][kk]);
            bv = sgn ? int'($signed(B[kk][j])) : int'(B[kk][j]);
            s += av * bv;
        end
        return AW'(s);
    endfunction

    task automatic fill(input int k, input logic [DW-1:0] va, input logic [DW-1:0] vb);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) A[i][kk] = va;
            for (int j = 0; j < C; j++) B[kk][j] = vb;
        end
    endtask

    task automatic fill_rand(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) A[i][kk] = DW'($urandom);
            for (int j = 0; j < C; j++) B[kk][j] = DW'($urandom);
        end
    endtask

    task automatic start_job(input int k, input bit sgn);
        start_i  = 1'b1;
        k_len_i  = KW'(k);
        signed_i = sgn;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("busy_after_start", w_t'(busy_o), w_t'(1));
    endtask

    // poke: hold start_i high and flip signed_i while the job is loading
    task automatic feed(input int n, input bit gaps, input bit poke);
        for (int kk = 0; kk < n; kk++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk_i); #1;
                end
            end
            for (int i = 0; i < R; i++) a_i[i*DW +: DW] = A[i][kk];
            for (int j = 0; j < C; j++) b_i[j*DW +: DW] = B[kk][j];
            if (poke && kk == 1) begin
                start_i  = 1'b1;
                k_len_i  = KW'(2);
                signed_i = ~signed_i;
            end
            in_valid_i = 1'b1;
            chk("in_ready_load", w_t'(in_ready_o), w_t'(1));
            @(posedge clk_i); #1;
            in_valid_i = 1'b0;
        end
        start_i = 1'b0;
        a_i = '1;
        b_i = '1;
    endtask

    // mode 0: reference model, 1: constant kval everywhere, 2: C[r][j] = 4r+j+1
    task automatic drain(input int k, input bit sgn, input int stall, input int exp_lat,
                         input int mode, input int kval, input string tag);
        int n;
        w_t hold_c;
        logic [RW-1:0] hold_r;
        logic [AW-1:0] e;
        n = 0;
        while (out_valid_o !== 1'b1 && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, "_valid_up"}, w_t'(out_valid_o), w_t'(1));
        if (exp_lat > 0) chk({tag, "_latency"}, w_t'(n), w_t'(exp_lat));
        for (int r = 0; r < R; r++) begin
            if (stall > 0) begin
                hold_c = c_o;
                hold_r = out_row_o;
                repeat (stall) begin
                    @(posedge clk_i); #1;
                end
                chk({tag, "_stall_c"}, c_o, hold_c);
                chk({tag, "_stall_row"}, w_t'(out_row_o), w_t'(hold_r));
                chk({tag, "_stall_valid"}, w_t'(out_valid_o), w_t'(1));
            end
            chk({tag, "_row"}, w_t'(out_row_o), w_t'(r));
            for (int j = 0; j < C; j++) begin
                if (mode == 1)      e = AW'(kval);
                else if (mode == 2) e = AW'(4*r + j + 1);
                else                e = ref_c(r, j, k, sgn);
                chk({tag, "_c"}, w_t'(c_o[j*AW +: AW]), w_t'(e));
            end
            out_ready_i = 1'b1;
            @(posedge clk_i); #1;
            out_ready_i = 1'b0;
        end
        chk({tag, "_done_hi"}, w_t'(done_o), w_t'(1));
        chk({tag, "_valid_lo"}, w_t'(out_valid_o), w_t'(0));
        chk({tag, "_c_zero"}, c_o, w_t'(0));
        chk({tag, "_idle"}, w_t'(busy_o), w_t'(0));
        @(posedge clk_i); #1;
        chk({tag, "_done_lo"}, w_t'(done_o), w_t'(0));
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        k_len_i     = '0;
        signed_i    = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        a_i         = '0;
        b_i         = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", w_t'(busy_o), w_t'(0));
        chk("rst_in_ready", w_t'(in_ready_o), w_t'(0));
        chk("rst_out_valid", w_t'(out_valid_o), w_t'(0));
        chk("rst_done", w_t'(done_o), w_t'(0));
        chk("rst_row", w_t'(out_row_o), w_t'(0));
        chk("rst_c", c_o, w_t'(0));
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        // Identity times B reproduces B
        for (int kk = 0; kk < 4; kk++) begin
            for (int i = 0; i < R; i++) A[i][kk] = DW'(i == kk);
            for (int j = 0; j < C; j++) B[kk][j] = DW'(4*kk + j + 1);
        end
        start_job(4, 1'b0);
        feed(4, 1'b0, 1'b0);
        drain(4, 1'b0, 0, 7, 2, 0, "ident");

        fill(1, 8'h80, 8'h80);
        start_job(1, 1'b1);
        feed(1, 1'b0, 1'b0);
        drain(1, 1'b1, 0, 7, 1, 16384, "s_k1");

        fill(1, 8'hFF, 8'hFF);
        start_job(1, 1'b0);
        feed(1, 1'b0, 1'b0);
        drain(1, 1'b0, 0, 0, 1, 65025, "u_k1");

        fill(16, 8'hFF, 8'hFF);
        start_job(16, 1'b0);
        feed(16, 1'b0, 1'b0);
        drain(16, 1'b0, 0, 7, 1, 1040400, "u_k16");

        fill(16, 8'h80, 8'h80);
        start_job(16, 1'b1);
        feed(16, 1'b0, 1'b0);
        drain(16, 1'b1, 0, 0, 1, 262144, "s_k16");

        // Gapped input, stalled output, start_i and signed_i poked mid-load
        fill_rand(7);
        start_job(7, 1'b0);
        feed(7, 1'b1, 1'b1);
        drain(7, 1'b0, 5, 0, 0, 0, "rand_u7");

        fill_rand(5);
        start_job(5, 1'b1);
        feed(5, 1'b1, 1'b0);
        drain(5, 1'b1, 2, 0, 0, 0, "rand_s5");

        // Invalid K values are ignored
        start_i = 1'b1;
        k_len_i = KW'(0);
        @(posedge clk_i); #1;
        chk("k0_busy", w_t'(busy_o), w_t'(0));
        k_len_i = KW'(17);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("k17_busy", w_t'(busy_o), w_t'(0));
        @(posedge clk_i); #1;
        chk("kbad_in_ready", w_t'(in_ready_o), w_t'(0));

        // Asynchronous reset mid-load
        fill(4, 8'hFF, 8'hFF);
        start_job(4, 1'b0);
        feed(2, 1'b0, 1'b0);
        #2 reset_i = 1'b1;
        #1;
        chk("rstload_busy", w_t'(busy_o), w_t'(0));
        chk("rstload_in_ready", w_t'(in_ready_o), w_t'(0));
        #2 reset_i = 1'b0;
        @(posedge clk_i); #1;

        // Asynchronous reset mid-drain
        fill(1, 8'hFF, 8'hFF);
        start_job(1, 1'b0);
        feed(1, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (out_valid_o !== 1'b1 && n < 40) begin
                @(posedge clk_i); #1;
                n++;
            end
            chk("rstdrain_valid_up", w_t'(out_valid_o), w_t'(1));
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("rstdrain_valid", w_t'(out_valid_o), w_t'(0));
        chk("rstdrain_c", c_o, w_t'(0));
        chk("rstdrain_row", w_t'(out_row_o), w_t'(0));
        chk("rstdrain_busy", w_t'(busy_o), w_t'(0));
        #2 reset_i = 1'b0;
        @(posedge clk_i); #1;

        fill_rand(2);
        start_job(2, 1'b0);
        feed(2, 1'b0, 1'b0);
        drain(2, 1'b0, 0, 7, 0, 0, "post_rst_k2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_os_stream_array.md
Name: mm_os_stream_array

Overview:
- Output-stationary systolic matrix engine computing C = A·B for A[ROWS×K] and B[K×COLS].
- Inner dimension K is programmable per job. Signed or unsigned operands are selected per job.
- Operands arrive one K-slice per beat over a valid/ready stream with internal skewing; results drain one row per beat over a valid/ready stream.
- Successor to the fixed N×N unsigned multiplier: adds rectangular shape, variable K, signed mode, backpressure on both sides, and a reusable job FSM.

Parameters:
- DATA_WIDTH, 8, operand width.
- ROWS, 4, PE rows (≥2).
- COLS, 4, PE columns (≥2).
- MAX_K, 16, largest supported inner dimension (≥1).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_K), accumulator and result width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  job start request, sampled in IDLE only.
- k_len_i  in  $clog2(MAX_K+1)  inner dimension K for the job.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- busy_o  out  1  high in every state except IDLE.
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  operand beat accepted when valid and ready are both high.
- a_i  in  ROWS×DATA_WIDTH  column k of A, element i for row i.
- b_i  in  COLS×DATA_WIDTH  row k of B, element j for column j.
- out_valid_o  out  1  result row valid.
- out_ready_i  in  1  downstream accepts the result row.
- out_row_o  out  $clog2(ROWS)  index of the row presented on c_o.
- c_o  out  COLS×ACC_WIDTH  C[out_row_o][0..COLS-1].
- done_o  out  1  one-cycle pulse after the final row is accepted.

Behaviour:
- Reset (async, any state): FSM→IDLE; all PE accumulators, pass registers and skew registers cleared.
  - Outputs under reset: busy_o=0, in_ready_o=0, out_valid_o=0, done_o=0, out_row_o=0, c_o=0.
  - An in-flight job is discarded and not resumed.
- IDLE:
  - start_i=1 with 1≤k_len_i≤MAX_K latches K and signed_i, clears accumulators and skew registers, and moves to LOAD on the next edge.
  - k_len_i=0 or k_len_i>MAX_K: start_i is ignored and the FSM stays in IDLE.
- start_i outside IDLE is ignored.
- LOAD:
  - in_ready_o=1.
  - Each accepted beat is one array step: row i input delayed i steps, column j input delayed j steps (skew registers advance only on steps).
  - Each PE does acc += west×north and forwards its operands east and south.
  - in_valid_i low means no step; all array state holds, and stalls of any length leave results unchanged.
  - On the K-th acceptance edge, go to FLUSH.
- FLUSH:
  - in_ready_o=0.
  - Array steps every cycle with zeros injected at all edges, for exactly ROWS+COLS-2 cycles, then go to DRAIN.
  - First out_valid_o cycle is ROWS+COLS-1 cycles after the last acceptance edge (7 for 4×4).
- DRAIN:
  - out_valid_o=1; out_row_o=r starting at 0; c_o=acc[r][*].
  - While out_ready_i=0, c_o and out_row_o hold stable.
  - Each handshake increments r. The handshake on r=ROWS-1 drops out_valid_o, pulses done_o for exactly the next cycle, and returns to IDLE.
- c_o is 0 whenever out_valid_o=0.
- start_i may be accepted in the cycle done_o is high; no bubble is required beyond that.
- Arithmetic:
  - Products are sign-extended (signed_i=1) or zero-extended (signed_i=0) to ACC_WIDTH.
  - Accumulation is modulo 2^ACC_WIDTH; ACC_WIDTH is sized so no overflow occurs for any K≤MAX_K.
  - Result is exact: C[i][j] = Σk A[i][k]·B[k][j].
- Mode is latched per job; changing signed_i mid-job has no effect.

Test Plan:
- 4×4, K=4, unsigned, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} → four rows equal to B; out_valid_o 7 cycles after the 4th acceptance; done_o pulses once.
- Signed, K=1, a_i all 8'h80 (−128), b_i all 8'h80 → every C=16384. Repeat unsigned with 8'hFF,8'hFF → 65025.
- K=MAX_K=16, unsigned, all operands 255 → every C=1040400 (no wrap). Signed, all −128 → every C=262144.
- Random A/B, K=7, in_valid_i toggled with random gaps, out_ready_i low 5 cycles per row → matches reference model; c_o and out_row_o stable while stalled.
- start_i with k_len_i=0 → busy_o stays 0. start_i during LOAD → ignored and the result is unaffected.
- reset_i asserted asynchronously mid-LOAD and mid-DRAIN → outputs zero immediately. A subsequent job with K=2 produces a correct result with no residue from the aborted job.
